seq_radix4_lpm_mult: RTL and testbench



---
 rtl/seq_radix4_lpm_mult.sv | 132 +++++++++++++
 tb/tb_seq_radix4_lpm_mult.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_radix4_lpm_mult.sv
// seq_radix4_lpm_mult: sequential radix-4 unsigned multiplier, one
// digit of a per clock, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with a, b;
// out_valid/out_ready with product (a*b, exact) and busy_cycles.
module seq_radix4_lpm_mult #(
    parameter int WIDTH_A    = 8,
    parameter int WIDTH_B    = 8,
    parameter int EARLY_TERM = 1,
    parameter int CW         = $clog2(WIDTH_A/2+2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic [CW-1:0]              busy_cycles
);
    localparam int ND   = ((WIDTH_A + 1) / 2) * 2;
    localparam int NDIG = ND / 2;
    localparam int P    = WIDTH_A + WIDTH_B;
    localparam int BW   = WIDTH_B + 2;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         r_state;
    logic [ND-1:0]  r_a_sh;
    logic [WIDTH_B-1:0] r_b;
    logic [BW-1:0]  r_b3;
    logic [P-1:0]   r_acc;
    logic [P-1:0]   r_pp;
    logic [CW-1:0]  r_k;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [P-1:0]   r_product;
    logic [CW-1:0]  r_busy;

    logic [1:0]     w_digit;
    logic [BW-1:0]  w_sel;
    logic           w_acc_en;
    logic [P-1:0]   w_pp_new;
    logic [P-1:0]   w_pp;
    logic [P-1:0]   w_sum;
    logic [P-1:0]   w_acc_next;
    logic [ND-1:0]  w_a_next;
    logic [CW-1:0]  w_k_inc;
    logic           w_last;

    assign w_digit = r_a_sh[1:0];

    // Decoder-style partial-product select: 0, b, 2b or the stored 3b.
    always_comb begin
        w_sel = '0;
        unique case (w_digit)
            2'd0: w_sel = '0;
            2'd1: w_sel = {2'b00, r_b};
            2'd2: w_sel = {1'b0, r_b, 1'b0};
            2'd3: w_sel = r_b3;
        endcase
    end

    // Zero digits leave the adder operands frozen so nothing toggles.
    assign w_acc_en   = (r_state == S_BUSY) && (w_digit != 2'd0);
    assign w_pp_new   = P'(w_sel) << {r_k, 1'b0};
    assign w_pp       = w_acc_en ? w_pp_new : r_pp;
    assign w_sum      = r_acc + w_pp;
    assign w_acc_next = w_acc_en ? w_sum : r_acc;
    assign w_a_next   = r_a_sh >> 2;
    assign w_k_inc    = r_k + 1'b1;
    assign w_last     = (r_k == CW'(NDIG - 1)) ||
                        ((EARLY_TERM != 0) && (w_a_next == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_busy      <= '0;
            r_acc       <= '0;
            r_pp        <= '0;
            r_a_sh      <= '0;
            r_b         <= '0;
            r_b3        <= '0;
            r_k         <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_b        <= b;
                        r_b3       <= BW'(b) + (BW'(b) << 1);
                        r_a_sh     <= ND'(a);
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_acc_en) begin
                        r_acc <= w_sum;
                        r_pp  <= w_pp_new;
                    end
                    r_a_sh <= w_a_next;
                    r_k    <= w_k_inc;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_product   <= w_acc_next;
                        r_busy      <= w_k_inc;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign product     = r_product;
    assign busy_cycles = r_busy;
endmodule

// File: tb/tb_seq_radix4_lpm_mult.sv
// tb_seq_radix4_lpm_mult: directed and random checks of three
// multiplier configurations against a queued a*b reference.
module tb_seq_radix4_lpm_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic iv [3];
    logic ordy [3];
    logic [7:0]  a8, b8;
    logic [6:0]  a7;
    logic [11:0] b12;

    logic in_rdy [3];
    logic o_val [3];
    logic [18:0] prod [3];
    logic [2:0]  busy [3];
    logic en [3];

    logic [15:0] p0, p1;
    logic [18:0] p2;
    logic [2:0]  c0, c1, c2;
    logic ir0, ir1, ir2, ov0, ov1, ov2;

    seq_radix4_lpm_mult #(.WIDTH_A(8), .WIDTH_B(8), .EARLY_TERM(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
        .a(a8), .b(b8), .out_valid(ov0), .out_ready(ordy[0]),
        .product(p0), .busy_cycles(c0));
    seq_radix4_lpm_mult #(.WIDTH_A(8), .WIDTH_B(8), .EARLY_TERM(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
        .a(a8), .b(b8), .out_valid(ov1), .out_ready(ordy[1]),
        .product(p1), .busy_cycles(c1));
    seq_radix4_lpm_mult #(.WIDTH_A(7), .WIDTH_B(12), .EARLY_TERM(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
        .a(a7), .b(b12), .out_valid(ov2), .out_ready(ordy[2]),
        .product(p2), .busy_cycles(c2));

    assign in_rdy[0] = ir0;  assign in_rdy[1] = ir1;  assign in_rdy[2] = ir2;
    assign o_val[0]  = ov0;  assign o_val[1]  = ov1;  assign o_val[2]  = ov2;
    assign prod[0]   = 19'(p0);
    assign prod[1]   = 19'(p1);
    assign prod[2]   = p2;
    assign busy[0]   = c0;   assign busy[1]   = c1;   assign busy[2]   = c2;
    assign en[0] = u0.w_acc_en;
    assign en[1] = u1.w_acc_en;
    assign en[2] = u2.w_acc_en;

    typedef struct {
        longint p;
        int     n;
    } exp_t;
    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    logic [31:0] en_log;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference latency: ET instance stops after its highest nonzero digit.
    function automatic int exp_n(input int u, input int av);
        int hi;
        if (u != 0) return 4;
        hi = 0;
        for (int i = 0; i < 4; i++)
            if (((av >> (2 * i)) & 3) != 0) hi = i + 1;
        return (hi < 1) ? 1 : hi;
    endfunction

    task automatic set_ops(input int u, input int av, input int bv);
        if (u == 2) begin
            a7 = 7'(av); b12 = 12'(bv);
        end else begin
            a8 = 8'(av); b8 = 8'(bv);
        end
    endtask

    task automatic do_op(input int u, input int av, input int bv, input int hold);
        int cyc;
        exp_t e;
        cyc = 0;
        while (!in_rdy[u] && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("in_ready_wait", longint'(in_rdy[u]), 1);
        set_ops(u, av, bv);
        e.p = longint'(av) * longint'(bv);
        e.n = exp_n(u, av);
        sb.push_back(e);
        ordy[u] = (hold == 0);
        iv[u] = 1'b1;
        @(posedge clk); #1;
        // With backpressure, keep a bogus request up through BUSY/DONE.
        if (hold > 0) set_ops(u, 99, 77);
        else iv[u] = 1'b0;
        en_log = '0;
        cyc = 0;
        while (!o_val[u] && cyc < 20) begin
            en_log[cyc] = en[u];
            @(posedge clk); #1; cyc++;
        end
        chk("out_valid_timeout", longint'(o_val[u]), 1);
        e = sb.pop_front();
        chk("latency", cyc, e.n);
        chk("product", prod[u], e.p);
        chk("busy_cycles", busy[u], e.n);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", longint'(o_val[u]), 1);
            chk("hold_product", prod[u], e.p);
            chk("hold_busy", busy[u], e.n);
            chk("hold_in_ready", longint'(in_rdy[u]), 0);
        end
        iv[u] = 1'b0;
        ordy[u] = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", longint'(o_val[u]), 0);
        chk("in_ready_back", longint'(in_rdy[u]), 1);
        chk("product_held", prod[u], e.p);
    endtask

    task automatic chk_reset(input int u);
        chk("rst_in_ready", longint'(in_rdy[u]), 1);
        chk("rst_out_valid", longint'(o_val[u]), 0);
        chk("rst_product", prod[u], 0);
        chk("rst_busy", busy[u], 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        a8 = '0; b8 = '0; a7 = '0; b12 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, 255, 255, 0);
        do_op(0, 3, 200, 0);
        do_op(1, 3, 200, 0);
        do_op(0, 0, 'hAB, 0);
        chk("en_zero_a", en_log[3:0], 0);
        do_op(0, 'h40, 'hFF, 0);
        chk("en_digits_0_2", en_log[2:0], 0);
        chk("en_digit_3", en_log[3], 1);
        do_op(0, 17, 13, 5);

        set_ops(0, 200, 150);
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk("midop_busy", longint'(o_val[0]), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset(0);
        do_op(0, 5, 7, 0);

        do_op(2, 127, 4095, 0);

        for (int i = 0; i < 1000; i++) begin
            int av, bv;
            av = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
            bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 4095));
            do_op(2, av, bv, 0);
        end
        for (int i = 0; i < 300; i++) begin
            int av, bv, u;
            u  = int'($urandom_range(0, 1));
            av = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op(u, av, bv, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
